// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RISC-V style load/store unit with a single-outstanding word
//               memory port. Define LSU_TIMEOUT_EN to enable the WAIT watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_f3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("load_store_unit: TIMEOUT must be at least 1");
    end

    state_t      r_state;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [31:0] r_rdata;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_byte_en;

    logic        w_f3_ok;
    logic        w_size_half;
    logic        w_size_word;
    logic        w_misaligned;
    logic        w_illegal;
    logic        w_start;
    logic [3:0]  w_byte_en;
    logic [31:0] w_wdata;
    logic [31:0] w_lane;
    logic [31:0] w_load;

    // Unsigned forms exist only for sub-word loads.
    always_comb begin
        w_f3_ok = 1'b0;
        case (req_f3)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = !req_write;
            default:                w_f3_ok = 1'b0;
        endcase
    end

    assign w_size_half  = (req_f3[1:0] == 2'b01);
    assign w_size_word  = (req_f3[1:0] == 2'b10);
    assign w_misaligned = (w_size_half && req_addr[0]) ||
                          (w_size_word && (req_addr[1:0] != 2'b00));
    assign w_illegal    = !w_f3_ok || w_misaligned;
    assign w_start      = (r_state == S_IDLE) && req_valid && !w_illegal;

    // Store data is replicated across lanes; byte enables pick the live ones.
    always_comb begin
        w_byte_en = 4'b1111;
        w_wdata   = req_wdata;
        if (w_size_half) begin
            w_byte_en = 4'b0011 << req_addr[1:0];
            w_wdata   = {2{req_wdata[15:0]}};
        end else if (!w_size_word) begin
            w_byte_en = 4'b0001 << req_addr[1:0];
            w_wdata   = {4{req_wdata[7:0]}};
        end
    end

    assign w_lane = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load = w_lane;
        case (r_f3)
            3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load = {24'd0, w_lane[7:0]};
            3'b101:  w_load = {16'd0, w_lane[15:0]};
            default: w_load = w_lane;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          r_tfault;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_f3      <= 3'd0;
            r_off     <= 2'd0;
            r_rdata   <= 32'd0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_byte_en <= 4'd0;
`ifdef LSU_TIMEOUT_EN
            r_cnt     <= '0;
            r_tfault  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_WAIT;
                        r_f3      <= req_f3;
                        r_off     <= req_addr[1:0];
                        r_we      <= req_write;
                        r_addr    <= {req_addr[31:2], 2'b00};
                        r_wdata   <= w_wdata;
                        r_byte_en <= w_byte_en;
`ifdef LSU_TIMEOUT_EN
                        r_cnt     <= '0;
                        r_tfault  <= 1'b0;
`endif
                    end
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        r_state <= S_DONE;
                        // Stores complete without disturbing the last load result.
                        if (!r_we) begin
                            r_rdata <= w_load;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state  <= S_DONE;
                        r_rdata  <= 32'd0;
                        r_tfault <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
`ifdef LSU_TIMEOUT_EN
                    r_tfault <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req     = (r_state == S_WAIT);
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_byte_en = r_byte_en;
    assign rsp_valid   = (r_state == S_DONE);
    assign rsp_rdata   = r_rdata;
    assign stall       = req_valid && (r_state != S_DONE) &&
                         !((r_state == S_IDLE) && w_illegal);

`ifdef LSU_TIMEOUT_EN
    assign fault = ((r_state == S_IDLE) && req_valid && w_illegal) ||
                   ((r_state == S_DONE) && r_tfault);
`else
    assign fault = (r_state == S_IDLE) && req_valid && w_illegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Randomised bench for load_store_unit with a transaction-level
//               reference model plus directed literal scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_f3(req_f3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .fault(fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int access_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit legal(input logic w, input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = access_bytes(f3);
        if (n == 0) return 1'b0;
        if (f3[2] && (w || n == 4)) return 1'b0;
        return (int'(a[1:0]) % n) == 0;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] word, input int off, input logic [2:0] f3);
        int n;
        logic [31:0] v;
        logic [31:0] m;
        n = access_bytes(f3);
        v = word >> (8 * off);
        if (n == 4) return v;
        m = (32'd1 << (8 * n)) - 32'd1;
        v = v & m;
        if (!f3[2] && v[8*n-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    int          m_phase = 0;   // 0 idle, 1 memory access pending, 2 response
    int          m_waited = 0;
    logic        m_tfault = 1'b0;
    logic        m_we = 1'b0;
    logic [2:0]  m_f3 = 3'd0;
    int          m_off = 0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [3:0]  m_be = 4'd0;
    logic [31:0] m_rdata = 32'd0;

    always @(negedge clk) begin : p_compare
        logic        lg;
        logic        e_stall;
        logic        e_fault;
        logic [31:0] mk;
        int          n;
        if (rst) begin
            m_phase = 0; m_tfault = 1'b0; m_we = 1'b0; m_addr = 32'd0;
            m_wdata = 32'd0; m_be = 4'd0; m_rdata = 32'd0;
        end
        lg      = legal(req_write, req_f3, req_addr);
        e_stall = (m_phase == 0) ? (req_valid && lg) : (m_phase == 1) ? req_valid : 1'b0;
        e_fault = (m_phase == 0 && req_valid && !lg) || (m_phase == 2 && m_tfault);
        mk      = lane_mask(m_be);
        check("stall",     {31'd0, stall},     {31'd0, e_stall});
        check("fault",     {31'd0, fault},     {31'd0, e_fault});
        check("mem_req",   {31'd0, mem_req},   {31'd0, m_phase == 1});
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_phase == 2});
        check("rsp_rdata", rsp_rdata, m_rdata);
        check("mem_we",    {31'd0, mem_we},    {31'd0, m_we});
        check("mem_addr",  mem_addr, m_addr);
        check("mem_be",    {28'd0, mem_byte_en}, {28'd0, m_be});
        check("mem_wdata", mem_wdata & mk, m_wdata & mk);
        if (!rst) begin
            case (m_phase)
                0: if (req_valid && lg) begin
                    n        = access_bytes(req_f3);
                    m_off    = int'(req_addr[1:0]);
                    m_phase  = 1;
                    m_waited = 0;
                    m_tfault = 1'b0;
                    m_we     = req_write;
                    m_f3     = req_f3;
                    m_addr   = req_addr & ~32'd3;
                    m_be     = 4'(((1 << n) - 1) << m_off);
                    m_wdata  = req_wdata << (8 * m_off);
                end
                1: if (mem_ready) begin
                    if (!m_we) m_rdata = extend(mem_rdata, m_off, m_f3);
                    m_phase = 2;
                end else begin
                    m_waited++;
`ifdef LSU_TIMEOUT_EN
                    if (m_waited == TIMEOUT) begin
                        m_phase  = 2;
                        m_rdata  = 32'd0;
                        m_tfault = 1'b1;
                    end
`endif
                end
                default: begin
                    m_phase  = 0;
                    m_tfault = 1'b0;
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        int   mdelay;
        int   nwait;
        int   nrsp;
        logic prev_stall;
        logic [2:0] f3_pick [8];
        f3_pick = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b010};

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_f3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        repeat (2) tick;
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        rst = 1'b0;

        // LB at byte lane 3, response in the first WAIT cycle
        req_valid = 1'b1; req_write = 1'b0; req_f3 = 3'b000; req_addr = 32'h103;
        @(negedge clk);
        check("lb_stall_idle", {31'd0, stall}, 32'd1);
        tick;
        mem_ready = 1'b1; mem_rdata = 32'h80FFFFFF;
        @(negedge clk);
        check("lb_byte_en", {28'd0, mem_byte_en}, 32'h8);
        check("lb_mem_addr", mem_addr, 32'h100);
        tick;
        mem_ready = 1'b0; mem_rdata = 32'h12345678;
        @(negedge clk);
        check("lb_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("lb_rdata", rsp_rdata, 32'hFFFFFF80);
        tick;

        // SH into the upper half
        req_write = 1'b1; req_f3 = 3'b001; req_addr = 32'h202; req_wdata = 32'h0000ABCD;
        tick;
        @(negedge clk);
        check("sh_mem_addr", mem_addr, 32'h200);
        check("sh_byte_en", {28'd0, mem_byte_en}, 32'hC);
        check("sh_wdata_hi", {16'd0, mem_wdata[31:16]}, 32'hABCD);
        check("sh_mem_we", {31'd0, mem_we}, 32'd1);
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        @(negedge clk);
        check("sh_rdata_held", rsp_rdata, 32'hFFFFFF80);
        tick;

        // misaligned LW never reaches memory
        req_write = 1'b0; req_f3 = 3'b010; req_addr = 32'h101;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lw_mis_fault", {31'd0, fault}, 32'd1);
            check("lw_mis_stall", {31'd0, stall}, 32'd0);
            check("lw_mis_req", {31'd0, mem_req}, 32'd0);
            tick;
        end

        // LHU with five stalled WAIT cycles
        req_f3 = 3'b101; req_addr = 32'h306; nrsp = 0;
        tick;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("lhu_req_hold", {31'd0, mem_req}, 32'd1);
            check("lhu_addr_hold", mem_addr, 32'h304);
            check("lhu_stall", {31'd0, stall}, 32'd1);
            if (rsp_valid) nrsp++;
            tick;
        end
        mem_ready = 1'b1; mem_rdata = 32'h87654321;
        tick;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                nrsp++;
                check("lhu_rdata", rsp_rdata, 32'h00008765);
            end
            tick;
            req_valid = 1'b0;
        end
        check("lhu_rsp_once", nrsp, 32'd1);

        // reset while the access is pending
        req_valid = 1'b1; req_f3 = 3'b010; req_addr = 32'h400;
        tick;
        tick;
        rst = 1'b1;
        #1;
        check("rst_req_drop", {31'd0, mem_req}, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        tick;
        mem_ready = 1'b0;

`ifdef LSU_TIMEOUT_EN
        req_valid = 1'b1; req_f3 = 3'b000; req_addr = 32'h0;
        tick;
        nwait = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (mem_req) nwait++;
            tick;
        end
        check("to_wait_cycles", nwait, TIMEOUT);
        check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("to_fault", {31'd0, fault}, 32'd1);
        check("to_rdata", rsp_rdata, 32'd0);
        tick;
        req_valid = 1'b0;
        tick;
`endif

        // randomised traffic with a responsive memory and occasional resets
        mdelay = -1;
        prev_stall = 1'b0;
        repeat (3000) begin
            if (!prev_stall) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_write = $urandom_range(0, 1) == 1;
                req_f3    = f3_pick[$urandom_range(0, 7)];
                req_addr  = $urandom_range(0, 1023);
                req_wdata = $urandom;
            end
            if (mem_req) begin
                if (mdelay < 0) mdelay = $urandom_range(0, 6);
                mem_ready = (mdelay == 0);
                if (mdelay > 0) mdelay--;
            end else begin
                mdelay = -1;
                mem_ready = ($urandom_range(0, 7) == 0);
            end
            mem_rdata = $urandom;
            rst = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            prev_stall = stall;
            tick;
        end
        rst = 1'b0; req_valid = 1'b0; mem_ready = 1'b0;
        repeat (3) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
